// File: rtl/mem_loader_ram_if.sv
// Loader byte stream and core memory bus shared by the RAM and whatever drives it.
interface mem_loader_ram_if #(
   parameter int unsigned WIDTH = 8
);
   // Loader stream
   logic             load_valid;
   logic [WIDTH-1:0] load_data;
   logic             load_last;
   logic             load_ready;
   // Core bus
   logic             memread;
   logic             memwrite;
   logic [WIDTH-1:0] adr;
   logic [WIDTH-1:0] writedata;
   logic [WIDTH-1:0] memdata;

   modport master (
      output load_valid, load_data, load_last, memread, memwrite, adr, writedata,
      input  load_ready, memdata
   );

   modport slave (
      input  load_valid, load_data, load_last, memread, memwrite, adr, writedata,
      output load_ready, memdata
   );
endinterface

// File: rtl/mem_loader_ram.sv
// Byte-wide program/data RAM for the multicycle core. Loads an image over a valid/ready
// stream while holding the core in reset, then serves the core bus with one mapped I/O byte.
module mem_loader_ram #(
   parameter int unsigned      WIDTH = 8,
   parameter logic [WIDTH-1:0] IOADR = {WIDTH{1'b1}}
) (
   input  logic               clk,
   input  logic               reset,
   mem_loader_ram_if.slave    bus,
   input  logic               reload,
   output logic               cpu_reset,
   input  logic [WIDTH-1:0]   io_in,
   output logic [WIDTH-1:0]   io_out,
   output logic [WIDTH:0]     load_count
);

   localparam int unsigned   Depth  = 2 ** WIDTH;
   localparam logic [WIDTH:0] PtrOne = {{WIDTH{1'b0}}, 1'b1};

   typedef enum logic [1:0] {StLoad, StFlush, StRun} state_e;

   state_e           state_q, state_d;
   // One bit wider than the address so a full image ends at Depth without wrapping.
   logic [WIDTH:0]   ptr_q, ptr_d;
   logic [WIDTH-1:0] io_out_q, io_out_d;
   logic [WIDTH-1:0] mem_q [Depth];

   logic             mem_we;
   logic [WIDTH-1:0] mem_waddr;
   logic [WIDTH-1:0] mem_wdata;

   // The read strobe carries no information for an always-readable async RAM.
   logic unused_memread;
   assign unused_memread = bus.memread;

   // Next-state, RAM write port and bus outputs for the load/flush/run sequence.
   always_comb begin
      state_d        = state_q;
      ptr_d          = ptr_q;
      io_out_d       = io_out_q;
      mem_we         = 1'b0;
      mem_waddr      = ptr_q[WIDTH-1:0];
      mem_wdata      = bus.load_data;
      bus.load_ready = 1'b0;
      bus.memdata    = '0;
      cpu_reset      = 1'b1;

      unique case (state_q)
         StLoad: begin
            bus.load_ready = 1'b1;
            if (bus.load_valid) begin
               mem_we = 1'b1;
               ptr_d  = ptr_q + PtrOne;
               if (bus.load_last || (ptr_q[WIDTH-1:0] == {WIDTH{1'b1}})) begin
                  state_d = StFlush;
               end
            end
         end
         // Guarantees the core sees cpu_reset on at least one edge after the last byte.
         StFlush: begin
            state_d = StRun;
         end
         StRun: begin
            cpu_reset   = 1'b0;
            bus.memdata = (bus.adr == IOADR) ? io_in : mem_q[bus.adr];
            if (bus.memwrite) begin
               if (bus.adr == IOADR) begin
                  io_out_d = bus.writedata;
               end else begin
                  mem_we    = 1'b1;
                  mem_waddr = bus.adr;
                  mem_wdata = bus.writedata;
               end
            end
            if (reload) begin
               state_d = StLoad;
               ptr_d   = '0;
            end
         end
         default: begin
            state_d = StLoad;
         end
      endcase
   end

   // Control state; RAM contents are deliberately outside the reset domain.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= StLoad;
         ptr_q    <= '0;
         io_out_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         io_out_q <= io_out_d;
      end
   end

   // RAM write port; reads are asynchronous so same-cycle reads see the old byte.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   // Bytes loaded equals the load pointer, which only moves on accepted bytes.
   assign load_count = ptr_q;
   assign io_out     = io_out_q;

endmodule

// File: tb/tb_mem_loader_ram.sv
// Bench for mem_loader_ram: directed vectors, an abstract reference model checked every
// falling edge, and literal expectations at key points of each scenario.
module tb_mem_loader_ram;

   logic       clk;
   logic       reset;
   logic       reload;
   logic       cpu_reset;
   logic [7:0] io_in;
   logic [7:0] io_out;
   logic [8:0] load_count;

   mem_loader_ram_if #(.WIDTH(8)) bus ();

   mem_loader_ram #(.WIDTH(8), .IOADR(8'hFF)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .reload     (reload),
      .cpu_reset  (cpu_reset),
      .io_in      (io_in),
      .io_out     (io_out),
      .load_count (load_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: phase 0 = loading, 1 = flush cycle, 2 = core running.
   int         m_phase;
   int         m_count;
   logic [7:0] m_io;
   logic [7:0] m_mem [256];
   bit         m_known [256];

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_phase <= 0;
         m_count <= 0;
         m_io    <= 8'h00;
      end else begin
         case (m_phase)
            0: if (bus.load_valid) begin
               m_mem[m_count]   <= bus.load_data;
               m_known[m_count] <= 1'b1;
               m_count          <= m_count + 1;
               if (bus.load_last || m_count == 255) m_phase <= 1;
            end
            1: m_phase <= 2;
            default: begin
               if (bus.memwrite) begin
                  if (bus.adr == 8'hFF) m_io <= bus.writedata;
                  else begin
                     m_mem[bus.adr]   <= bus.writedata;
                     m_known[bus.adr] <= 1'b1;
                  end
               end
               if (reload) begin
                  m_phase <= 0;
                  m_count <= 0;
               end
            end
         endcase
      end
   end

   // Every falling edge: outputs must agree with the model.
   always @(negedge clk) begin
      if (cmp_en && reset) begin
         chk("load_ready", {31'b0, bus.load_ready}, (m_phase == 0) ? 1 : 0);
         chk("cpu_reset", {31'b0, cpu_reset}, (m_phase == 2) ? 0 : 1);
         chk("load_count", {23'b0, load_count}, m_count);
         chk("io_out", {24'b0, io_out}, {24'b0, m_io});
         if (m_phase != 2) chk("memdata_idle", {24'b0, bus.memdata}, 0);
         else if (bus.adr == 8'hFF) chk("memdata_io", {24'b0, bus.memdata}, {24'b0, io_in});
         else if (m_known[bus.adr]) chk("memdata_ram", {24'b0, bus.memdata},
                                        {24'b0, m_mem[bus.adr]});
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [7:0] d, input bit last);
      bus.load_valid = 1'b1;
      bus.load_data  = d;
      bus.load_last  = last;
      tick();
      bus.load_valid = 1'b0;
      bus.load_last  = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   task automatic core_read(input logic [7:0] a, output logic [7:0] d);
      bus.memread = 1'b1;
      bus.adr     = a;
      #1 d = bus.memdata;
      tick();
      bus.memread = 1'b0;
   endtask

   logic [7:0] t2_exp [4];
   logic [7:0] img [6];
   logic [7:0] pa, pb, dst, va, vb;
   bit         ran;

   initial begin
      reset          = 1'b0;
      reload         = 1'b0;
      io_in          = 8'h00;
      bus.load_valid = 1'b0;
      bus.load_data  = 8'h00;
      bus.load_last  = 1'b0;
      bus.memread    = 1'b0;
      bus.memwrite   = 1'b0;
      bus.adr        = 8'h00;
      bus.writedata  = 8'h00;
      t2_exp = '{8'h11, 8'h22, 8'h33, 8'h44};
      img    = '{8'h04, 8'h05, 8'hFF, 8'h00, 8'h21, 8'h13};

      // Reset state
      tick();
      tick();
      chk("rst_ready", {31'b0, bus.load_ready}, 1);
      chk("rst_cpu_reset", {31'b0, cpu_reset}, 1);
      chk("rst_count", {23'b0, load_count}, 0);
      chk("rst_io_out", {24'b0, io_out}, 0);
      reset  = 1'b1;
      cmp_en = 1'b1;

      // 1: four-byte image, flush, run
      send(8'h80, 1'b0);
      send(8'h00, 1'b0);
      send(8'h03, 1'b0);
      send(8'hA0, 1'b1);
      chk("t1_count", {23'b0, load_count}, 4);
      chk("t1_flush_ready", {31'b0, bus.load_ready}, 0);
      chk("t1_flush_cpu_reset", {31'b0, cpu_reset}, 1);
      tick();
      chk("t1_run_cpu_reset", {31'b0, cpu_reset}, 0);
      bus.adr = 8'h01;
      #1 chk("t1_rd1", {24'b0, bus.memdata}, 8'h00);
      bus.adr = 8'h03;
      #1 chk("t1_rd3", {24'b0, bus.memdata}, 8'hA0);

      // 2: gaps, stray load_last and reload while loading
      do_reset();
      send(8'h11, 1'b0);
      send(8'h22, 1'b0);
      reload = 1'b1;
      tick();
      reload = 1'b0;
      tick();
      bus.load_last = 1'b1;
      tick();
      bus.load_last = 1'b0;
      chk("t2_gap_count", {23'b0, load_count}, 2);
      chk("t2_gap_ready", {31'b0, bus.load_ready}, 1);
      send(8'h33, 1'b0);
      send(8'h44, 1'b1);
      tick();
      chk("t2_run", {31'b0, cpu_reset}, 0);
      for (int i = 0; i < 4; i++) begin
         bus.adr = 8'(i);
         #1 chk("t2_rd", {24'b0, bus.memdata}, {24'b0, t2_exp[i]});
      end

      // 3: full 256-byte image without load_last
      do_reset();
      for (int i = 0; i < 256; i++) begin
         send(8'(i) ^ 8'h5A, 1'b0);
         if (i == 254) begin
            chk("t3_pre_ready", {31'b0, bus.load_ready}, 1);
            chk("t3_pre_count", {23'b0, load_count}, 255);
         end
      end
      chk("t3_count", {23'b0, load_count}, 256);
      chk("t3_flush_ready", {31'b0, bus.load_ready}, 0);
      bus.load_valid = 1'b1;
      bus.load_data  = 8'hEE;
      tick();
      chk("t3_run", {31'b0, cpu_reset}, 0);
      tick();
      bus.load_valid = 1'b0;
      chk("t3_count_hold", {23'b0, load_count}, 256);
      bus.adr = 8'h00;
      #1 chk("t3_byte0", {24'b0, bus.memdata}, 8'h5A);

      // 4: I/O byte
      io_in         = 8'hC3;
      bus.adr       = 8'hFF;
      bus.writedata = 8'h5A;
      bus.memwrite  = 1'b1;
      #1 chk("t4_io_rd_pre", {24'b0, bus.memdata}, 8'hC3);
      tick();
      bus.memwrite = 1'b0;
      chk("t4_io_out", {24'b0, io_out}, 8'h5A);
      #1 chk("t4_io_rd", {24'b0, bus.memdata}, 8'hC3);

      // 5: RAM write, same-cycle old data, reload keeps RAM and io_out
      bus.adr       = 8'h10;
      bus.writedata = 8'h77;
      bus.memwrite  = 1'b1;
      #1 chk("t5_old", {24'b0, bus.memdata}, 8'h4A);
      tick();
      bus.memwrite = 1'b0;
      #1 chk("t5_new", {24'b0, bus.memdata}, 8'h77);
      reload = 1'b1;
      tick();
      reload = 1'b0;
      chk("t5_cpu_reset", {31'b0, cpu_reset}, 1);
      chk("t5_ready", {31'b0, bus.load_ready}, 1);
      chk("t5_count", {23'b0, load_count}, 0);
      chk("t5_io_keep", {24'b0, io_out}, 8'h5A);
      send(8'h99, 1'b1);
      tick();
      bus.adr = 8'h10;
      #1 chk("t5_ram_keep", {24'b0, bus.memdata}, 8'h77);
      bus.adr = 8'h00;
      #1 chk("t5_new0", {24'b0, bus.memdata}, 8'h99);

      // 6: async abort mid-load, then reload and run a tiny program
      do_reset();
      send(8'h01, 1'b0);
      send(8'h02, 1'b0);
      #2 reset = 1'b0;
      #1;
      chk("t6_abort_count", {23'b0, load_count}, 0);
      chk("t6_abort_ready", {31'b0, bus.load_ready}, 1);
      chk("t6_abort_cpu_reset", {31'b0, cpu_reset}, 1);
      chk("t6_abort_io", {24'b0, io_out}, 0);
      tick();
      reset = 1'b1;
      for (int i = 0; i < 6; i++) send(img[i], i == 5);
      ran = 1'b0;
      for (int i = 0; i < 10 && !ran; i++) begin
         if (!cpu_reset) ran = 1'b1;
         else tick();
      end
      chk("t6_core_released", {31'b0, ran}, 1);
      // Core stand-in: io[mem[2]] = mem[mem[0]] + mem[mem[1]]
      core_read(8'h00, pa);
      core_read(8'h01, pb);
      core_read(8'h02, dst);
      core_read(pa, va);
      core_read(pb, vb);
      bus.adr       = dst;
      bus.writedata = va + vb;
      bus.memwrite  = 1'b1;
      tick();
      bus.memwrite = 1'b0;
      chk("t6_io_out", {24'b0, io_out}, 8'h34);

      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
